code_decoder_fifo: RTL and testbench
====================================

# code_decoder_fifo

Buffered binary-to-one-hot decoder: the return path for the 2-bit codes our priority encoder produces. It queues incoming codes in a small FIFO and presents each one, decoded to one-hot, on a valid/ack output port. Each one-hot word is held stable until the consumer acknowledges it. The `enb` input gates output presentation, matching the encoder's enable semantics: disabled means all-zero output.

## Interface
- `IDX_W`, default 2: code width; one-hot width is `2**IDX_W`.
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enb`  in  1  output enable; low masks the output and stalls dequeue.
- `in_vld`  in  1  producer has a code on `in_code`.
- `in_code`  in  IDX_W  code to decode.
- `in_rdy`  out  1  FIFO can accept; combinational, equal to `count < DEPTH`.
- `out_vld`  out  1  `out_onehot`/`out_code` hold a valid entry.
- `out_onehot`  out  2**IDX_W  `1 << out_code` when `out_vld`, else all zero.
- `out_code`  out  IDX_W  raw code of the presented entry.
- `out_ack`  in  1  consumer accepts the presented entry.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the presented entry.

## Operation
- **Push:** a code is written when `in_vld && in_rdy` at a rising edge. The write pointer increments modulo DEPTH.
- **Full:** with `count == DEPTH`, `in_rdy` is 0. A push is refused even if a pop happens in the same cycle (no same-cycle write-through).
- **Output stage:** an FSM with two states, IDLE and HOLD, plus a holding register `hold_code`.
  - **IDLE:** if `enb && count > 0`, load the FIFO head into `hold_code`, pop, and go to HOLD. Otherwise stay in IDLE.
  - **HOLD:**
    - If `enb && out_ack` and `count > 0`: load the next head, pop, and stay in HOLD (back-to-back, no bubble).
    - If `enb && out_ack` and `count == 0`: go to IDLE.
    - Otherwise: hold.
- **Output values:** `out_vld = (state == HOLD) && enb`.
  - `out_onehot` = `1 << hold_code` when `out_vld`, else 0.
  - `out_code` = `hold_code` regardless of `out_vld`.
- **`enb` low:**
  - No pops.
  - `out_ack` is ignored.
  - `out_vld` and `out_onehot` are 0.
  - `hold_code` and the FIFO are preserved.
  - Pushes continue normally.
- **Simultaneous push and pop:** both happen. `count` is unchanged and both pointers advance.
- **`out_ack` in IDLE:** ignored.
- **Pointer wrap:** pointers are `$clog2(DEPTH)` bits and wrap naturally. Full/empty are determined by `count`, not by pointer comparison.

## Timing
- **Reset (asynchronous, `rst_n = 0`):**
  - Values: state = IDLE, pointers = 0, `count` = 0, `hold_code` = 0, `out_vld` = 0, `out_onehot` = 0, `out_code` = 0.
  - `in_rdy` reads 1 during and after reset.
  - A reset asserted mid-operation discards all queued and presented entries immediately, without waiting for a clock edge.
- **Latency, empty queue:** a code accepted at edge N appears with `out_vld = 1` after edge N+1, i.e. 2 edges from acceptance to presentation.
- **Throughput:** with a non-empty FIFO and `out_ack` held high, one entry is delivered per cycle.
- **Hold rule:** `out_onehot` and `out_code` must not change while `out_vld = 1 && !out_ack`.
- **Combinational paths:**
  - `enb` → `out_vld`/`out_onehot` is combinational, so deasserting `enb` masks the output in the same cycle.
  - There is no combinational path from `out_ack` to any output.

## Test plan
- **Reset:** assert `rst_n = 0` mid-transfer with 3 entries queued → `count = 0`, `out_vld = 0`, `out_onehot = 4'b0000` before the next edge; `in_rdy = 1`.
- **Single decode:** `enb = 1`, push code 2'b10 → `out_vld` rises 2 edges later with `out_onehot = 4'b0100`, `out_code = 2'b10`. Output is held for 5 cycles without ack, then returns to IDLE one edge after ack.
- **Streaming:** push 0, 1, 2, 3 back-to-back, then hold `out_ack = 1` → `out_onehot` sequence is 0001, 0010, 0100, 1000 on consecutive cycles, then `out_vld = 0`.
- **Full:** push 4 codes with `enb = 0` → `count = 4`, `in_rdy = 0`. A fifth push, attempted while a pop occurs, is refused. Codes delivered in order after wrap, with no loss or duplication.
- **Enable gating:** during HOLD of code 3, drive `enb = 0` for 3 cycles with `out_ack = 1` → `out_onehot = 0000` and the entry is not consumed. After `enb = 1`, code 3 reappears as 1000.
- **Simultaneous push/pop:** at `count = 2`, push and ack in the same cycle → `count` stays 2 and ordering is preserved.

Source files
------------

// File: rtl/code_decoder_fifo_if.sv
// Handshake bundle for the buffered code decoder.
// Producer/consumer side uses master, the decoder uses slave.
interface code_decoder_fifo_if #(
  parameter int IDX_W = 2,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = 2 ** IDX_W;

  logic             enb;
  logic             in_vld;
  logic [IDX_W-1:0] in_code;
  logic             in_rdy;
  logic             out_vld;
  logic [OW-1:0]    out_onehot;
  logic [IDX_W-1:0] out_code;
  logic             out_ack;
  logic [CW-1:0]    count;

  modport master (
    output enb, in_vld, in_code, out_ack,
    input  in_rdy, out_vld, out_onehot, out_code, count
  );

  modport slave (
    input  enb, in_vld, in_code, out_ack,
    output in_rdy, out_vld, out_onehot, out_code, count
  );
endinterface

// File: rtl/code_decoder_fifo.sv
// Queues 2-bit codes and presents each one decoded to one-hot
// on a valid/ack port, held stable until acknowledged.
module code_decoder_fifo #(
  parameter int IDX_W = 2,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  code_decoder_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = 2 ** IDX_W;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [IDX_W-1:0] hold_code;
  logic             push;
  logic             pop;
  logic             nonempty;

  assign nonempty = (cnt != '0);
  assign push     = bus.in_vld && bus.in_rdy;
  // Pop only when the presented slot is free or being acked.
  assign pop      = bus.enb && nonempty &&
                    ((state == IDLE) || bus.out_ack);

  assign bus.in_rdy     = (cnt < CW'(DEPTH));
  assign bus.count      = cnt;
  assign bus.out_vld    = (state == HOLD) && bus.enb;
  assign bus.out_code   = hold_code;
  assign bus.out_onehot = bus.out_vld ?
                          (OW'(1) << hold_code) : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_code <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            hold_code <= mem[rd_ptr];
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.enb && bus.out_ack) begin
            if (pop) hold_code <= mem[rd_ptr];
            else     state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_code_decoder_fifo.sv
// Scoreboard bench for code_decoder_fifo: accepted codes are queued
// and compared against each acknowledged output entry.
module tb_code_decoder_fifo;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [1:0] sb [$];

  code_decoder_fifo_if #(.IDX_W(2), .DEPTH(4)) bus ();

  code_decoder_fifo #(.IDX_W(2), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge rst_n) sb.delete();

  // Delivery check first, then record any accepted push.
  always @(posedge clk) begin
    logic [1:0] e;
    logic [3:0] eo;
    if (rst_n) begin
      if (bus.out_vld && bus.out_ack) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got code=%0d expected none",
                   bus.out_code);
        end else begin
          e  = sb.pop_front();
          eo = 4'b0001 << e;
          if (bus.out_code !== e || bus.out_onehot !== eo) begin
            errors++;
            $display("FAIL sb_delivery got %0d/%b expected %0d/%b",
                     bus.out_code, bus.out_onehot, e, eo);
          end
        end
      end
      if (bus.in_vld && bus.in_rdy) sb.push_back(bus.in_code);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_code(input logic [1:0] c);
    bus.in_vld  = 1'b1;
    bus.in_code = c;
    tick();
    bus.in_vld  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    bus.out_ack = 1'b1;
    while ((bus.out_vld || bus.count != 0) && n < 20) begin
      tick();
      n++;
    end
    bus.out_ack = 1'b0;
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL %s_drain_timeout got %0d cycles expected <20",
               name, n);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_left got %0d entries expected 0",
               name, sb.size());
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.count !== 3'd0 || bus.in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_cnt got count=%0d rdy=%b expected 0/1",
               bus.count, bus.in_rdy);
    end
    checks++;
    if (bus.out_vld !== 1'b0 || bus.out_onehot !== 4'b0000 ||
        bus.out_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_out got %b/%b/%0d expected 0/0000/0",
               bus.out_vld, bus.out_onehot, bus.out_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    push_code(2'd2);
    checks++;
    if (bus.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_early got vld=%b expected 0", bus.out_vld);
    end
    tick();
    checks++;
    if (bus.out_vld !== 1'b1 || bus.out_onehot !== 4'b0100 ||
        bus.out_code !== 2'd2) begin
      errors++;
      $display("FAIL single_present got %b/%b/%0d expected 1/0100/2",
               bus.out_vld, bus.out_onehot, bus.out_code);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.out_vld !== 1'b1 || bus.out_onehot !== 4'b0100) begin
        errors++;
        $display("FAIL single_hold%0d got %b/%b expected 1/0100",
                 i, bus.out_vld, bus.out_onehot);
      end
    end
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    checks++;
    if (bus.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got vld=%b expected 0", bus.out_vld);
    end
  endtask

  task automatic test_streaming();
    logic [3:0] eo;
    for (int i = 0; i < 4; i++) push_code(2'(i));
    bus.out_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eo = 4'b0001 << i;
      checks++;
      if (bus.out_vld !== 1'b1 || bus.out_onehot !== eo) begin
        errors++;
        $display("FAIL stream%0d got %b/%b expected 1/%b",
                 i, bus.out_vld, bus.out_onehot, eo);
      end
      tick();
    end
    bus.out_ack = 1'b0;
    checks++;
    if (bus.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL stream_end got vld=%b expected 0", bus.out_vld);
    end
  endtask

  task automatic test_full();
    bus.enb = 1'b0;
    push_code(2'd1);
    push_code(2'd3);
    push_code(2'd0);
    push_code(2'd2);
    checks++;
    if (bus.count !== 3'd4 || bus.in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_state got count=%0d rdy=%b expected 4/0",
               bus.count, bus.in_rdy);
    end
    bus.enb = 1'b1;
    push_code(2'd3);
    checks++;
    if (bus.count !== 3'd3 || bus.out_code !== 2'd1) begin
      errors++;
      $display("FAIL full_refuse got count=%0d code=%0d expected 3/1",
               bus.count, bus.out_code);
    end
    drain("full");
  endtask

  task automatic test_enable();
    push_code(2'd3);
    tick();
    checks++;
    if (bus.out_onehot !== 4'b1000) begin
      errors++;
      $display("FAIL enb_pre got %b expected 1000", bus.out_onehot);
    end
    bus.enb     = 1'b0;
    bus.out_ack = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_vld !== 1'b0 || bus.out_onehot !== 4'b0000 ||
          bus.out_code !== 2'd3) begin
        errors++;
        $display("FAIL enb_mask%0d got %b/%b/%0d expected 0/0000/3",
                 i, bus.out_vld, bus.out_onehot, bus.out_code);
      end
      tick();
    end
    bus.out_ack = 1'b0;
    bus.enb     = 1'b1;
    #1;
    checks++;
    if (bus.out_vld !== 1'b1 || bus.out_onehot !== 4'b1000) begin
      errors++;
      $display("FAIL enb_back got %b/%b expected 1/1000",
               bus.out_vld, bus.out_onehot);
    end
    drain("enb");
  endtask

  task automatic test_simul();
    push_code(2'd1);
    push_code(2'd2);
    push_code(2'd3);
    checks++;
    if (bus.count !== 3'd2 || bus.out_code !== 2'd1) begin
      errors++;
      $display("FAIL simul_pre got count=%0d code=%0d expected 2/1",
               bus.count, bus.out_code);
    end
    bus.out_ack = 1'b1;
    push_code(2'd0);
    bus.out_ack = 1'b0;
    checks++;
    if (bus.count !== 3'd2 || bus.out_code !== 2'd2) begin
      errors++;
      $display("FAIL simul_post got count=%0d code=%0d expected 2/2",
               bus.count, bus.out_code);
    end
    drain("simul");
  endtask

  task automatic test_reset_mid();
    bus.enb = 1'b0;
    for (int i = 0; i < 4; i++) push_code(2'(3 - i));
    bus.enb = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.count !== 3'd0 || bus.in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_cnt got count=%0d rdy=%b expected 0/1",
               bus.count, bus.in_rdy);
    end
    checks++;
    if (bus.out_vld !== 1'b0 || bus.out_onehot !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_out got %b/%b expected 0/0000",
               bus.out_vld, bus.out_onehot);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.out_vld !== 1'b0 || bus.count !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_after got vld=%b count=%0d expected 0/0",
               bus.out_vld, bus.count);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.enb     = 1'b1;
    bus.in_vld  = 1'b0;
    bus.in_code = 2'd0;
    bus.out_ack = 1'b0;
    test_reset();
    test_single();
    test_streaming();
    test_full();
    test_enable();
    test_simul();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
